draw_scheduler: RTL and testbench

- Shares the single VGA adapter write port (x, y, colour, plot) between several drawing requesters: screen clear, left paddle, right paddle, ball.
- Each requester presents a filled rectangle. The scheduler grants one requester at a time in round-robin order and rasterises its rectangle one pixel per clock.
- It signals completion back to the requester. It sits between the game control FSM and the vga_adapter, replacing the per-object set_up/draw sequencing.

---
 rtl/draw_pkg.sv | 26 ++
 rtl/draw_scheduler_if.sv | 35 +++
 rtl/draw_scheduler_rr_arbiter.sv | 33 +++
 rtl/draw_scheduler.sv | 163 ++++++++++++++++
 tb/tb_draw_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/draw_pkg.sv
// Shared constants for the draw scheduler: requester indices, FSM
// state encoding and default geometry.
package draw_pkg;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_X_W      = 9;
    localparam int DEF_Y_W      = 8;
    localparam int DEF_COL_W    = 3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    localparam int REQ_CLEAR = 0;
    localparam int REQ_LPAD  = 1;
    localparam int REQ_RPAD  = 2;
    localparam int REQ_BALL  = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DRAW = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Requester/adapter bundle of the draw scheduler.
// master: requesters (req, rect_*), slave: scheduler (grant, done, busy, pixel bus).
interface draw_scheduler_if
    import draw_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int X_W     = DEF_X_W,
    parameter int Y_W     = DEF_Y_W,
    parameter int COL_W   = DEF_COL_W
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*X_W-1:0]   rect_x;
    logic [NUM_REQ*Y_W-1:0]   rect_y;
    logic [NUM_REQ*X_W-1:0]   rect_w;
    logic [NUM_REQ*Y_W-1:0]   rect_h;
    logic [NUM_REQ*COL_W-1:0] rect_colour;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [COL_W-1:0]         colour;
    logic                     plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  grant, done, busy, x, y, colour, plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output grant, done, busy, x, y, colour, plot
    );

endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set req bit from ptr upward.
// Ports: req, ptr in; pick (one-hot, zero if none) and idx out.
module rr_arbiter
    import draw_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   idx
);

    int               j;
    logic [IDX_W-1:0] jj;

    always_comb begin
        pick = '0;
        idx  = '0;
        j    = 0;
        jj   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j  = (int'(ptr) + i) % NUM_REQ;
            jj = IDX_W'(j);
            if (pick == '0 && req[jj]) begin
                pick[jj] = 1'b1;
                idx      = jj;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA adapter write port between requesters, rasterising one
// granted rectangle a pixel per clock. Ports: clk, reset, bus (slave).
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COL_W    = DEF_COL_W,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input logic              clk,
    input logic              reset,
    draw_scheduler_if.slave  bus
);

    localparam int IDX_W = idx_w(NUM_REQ);
    localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic               plot;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COL_W-1:0]   colour;

    logic [X_W-1:0]     bx, bw, cx;
    logic [Y_W-1:0]     by, bh, cy;
    logic [COL_W-1:0]   bcol;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;

    logic [X_W-1:0]     lx, lw;
    logic [Y_W-1:0]     ly, lh;
    logic [COL_W-1:0]   lcol;

    logic               last_col, last_row;
    logic [X_W-1:0]     ncx, base_x, off_x;
    logic [Y_W-1:0]     ncy, base_y, off_y;
    logic [X_W:0]       sx;
    logic [Y_W:0]       sy;
    logic               on_screen;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req  (bus.req),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    assign lx   = bus.rect_x[owner*X_W +: X_W];
    assign ly   = bus.rect_y[owner*Y_W +: Y_W];
    assign lw   = bus.rect_w[owner*X_W +: X_W];
    assign lh   = bus.rect_h[owner*Y_W +: Y_W];
    assign lcol = bus.rect_colour[owner*COL_W +: COL_W];

    // Outputs are registered, so each edge computes the pixel shown in
    // the following cycle: pixel (0,0) from the live inputs in LOAD,
    // the next raster position from the latched copy in DRAW.
    always_comb begin
        last_col = (cx == bw - 1'b1);
        last_row = (cy == bh - 1'b1);
        ncx      = last_col ? '0 : cx + 1'b1;
        ncy      = last_col ? cy + 1'b1 : cy;
        base_x   = (state == LOAD) ? lx : bx;
        base_y   = (state == LOAD) ? ly : by;
        off_x    = (state == LOAD) ? '0 : ncx;
        off_y    = (state == LOAD) ? '0 : ncy;
        sx       = {1'b0, base_x} + {1'b0, off_x};
        sy       = {1'b0, base_y} + {1'b0, off_y};
        on_screen = (sx < SW) && (sy < SH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            grant  <= '0;
            done   <= '0;
            plot   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            bx     <= '0;
            by     <= '0;
            bw     <= '0;
            bh     <= '0;
            bcol   <= '0;
            cx     <= '0;
            cy     <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        owner <= pick_idx;
                        grant <= pick;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    bx   <= lx;
                    by   <= ly;
                    bw   <= lw;
                    bh   <= lh;
                    bcol <= lcol;
                    cx   <= '0;
                    cy   <= '0;
                    if (lw == '0 || lh == '0) begin
                        state <= DONE;
                        done  <= grant;
                        plot  <= 1'b0;
                    end else begin
                        state  <= DRAW;
                        x      <= sx[X_W-1:0];
                        y      <= sy[Y_W-1:0];
                        colour <= lcol;
                        plot   <= on_screen;
                    end
                end
                DRAW: begin
                    if (last_col && last_row) begin
                        state <= DONE;
                        done  <= grant;
                        plot  <= 1'b0;
                    end else begin
                        cx     <= ncx;
                        cy     <= ncy;
                        x      <= sx[X_W-1:0];
                        y      <= sy[Y_W-1:0];
                        colour <= bcol;
                        plot   <= on_screen;
                    end
                end
                DONE: begin
                    grant <= '0;
                    state <= IDLE;
                    ptr   <= (owner == IDX_W'(NUM_REQ-1)) ? '0 : owner + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant  = grant;
    assign bus.done   = done;
    assign bus.busy   = (state != IDLE);
    assign bus.plot   = plot;
    assign bus.x      = x;
    assign bus.y      = y;
    assign bus.colour = colour;

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: directed cases then randomized
// requests checked against a per-rectangle raster model.
module tb_draw_scheduler
    import draw_pkg::*;
;

    logic clk;
    logic reset;

    int checks;
    int errors;
    int ptr_m;
    int rx[4];
    int ry[4];
    int rw[4];
    int rh[4];
    int rc[4];

    draw_scheduler_if bus ();

    draw_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < 4; i++) begin
            bus.rect_x[i*9 +: 9]      = 9'(rx[i]);
            bus.rect_y[i*8 +: 8]      = 8'(ry[i]);
            bus.rect_w[i*9 +: 9]      = 9'(rw[i]);
            bus.rect_h[i*8 +: 8]      = 8'(rh[i]);
            bus.rect_colour[i*3 +: 3] = 3'(rc[i]);
        end
    endtask

    task automatic set_rect(input int i, input int x0, input int y0,
                            input int w0, input int h0, input int c0);
        rx[i] = x0;
        ry[i] = y0;
        rw[i] = w0;
        rh[i] = h0;
        rc[i] = c0;
        pack();
    endtask

    // Called while the DUT is in IDLE, before the edge that samples req.
    task automatic run_txn(input bit chg, input bit drop);
        int own, sx, sy, sw, sh, sc, n, px, py;
        bit on;
        own = -1;
        for (int k = 0; k < 4; k++) begin
            if (own < 0 && bus.req[(ptr_m + k) % 4]) own = (ptr_m + k) % 4;
        end
        chk("req_present", 32'(own >= 0), 32'd1);
        if (own < 0) own = 0;
        sx = rx[own]; sy = ry[own]; sw = rw[own]; sh = rh[own]; sc = rc[own];
        tick();
        chk("grant", 32'(bus.grant), 32'(1 << own));
        chk("busy_load", 32'(bus.busy), 32'd1);
        chk("plot_load", 32'(bus.plot), 32'd0);
        n = 0;
        for (int r = 0; r < sh; r++) begin
            for (int c = 0; c < sw; c++) begin
                tick();
                px = sx + c;
                py = sy + r;
                on = (px < 160) && (py < 120);
                chk("plot", 32'(bus.plot), 32'(on));
                if (on) begin
                    chk("x", 32'(bus.x), 32'(px % 512));
                    chk("y", 32'(bus.y), 32'(py % 256));
                    chk("colour", 32'(bus.colour), 32'(sc));
                end
                n++;
                if (chg && n == 4) begin
                    rx[own] = 50;
                    pack();
                end
                if (drop && n == 1) bus.req[own] = 1'b0;
            end
        end
        tick();
        chk("done", 32'(bus.done), 32'(1 << own));
        chk("plot_done", 32'(bus.plot), 32'd0);
        chk("grant_done", 32'(bus.grant), 32'(1 << own));
        tick();
        chk("grant_idle", 32'(bus.grant), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("done_idle", 32'(bus.done), 32'd0);
        ptr_m = (own + 1) % 4;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        ptr_m = 0;
        #1;
        chk("rst_plot", 32'(bus.plot), 32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        checks = 0;
        errors = 0;
        ptr_m  = 0;
        reset  = 1'b1;
        bus.req = '0;
        for (int i = 0; i < 4; i++) set_rect(i, 0, 0, 1, 1, 0);
        tick();
        tick();
        chk("init_grant", 32'(bus.grant), 32'd0);
        chk("init_done", 32'(bus.done), 32'd0);
        chk("init_busy", 32'(bus.busy), 32'd0);
        chk("init_plot", 32'(bus.plot), 32'd0);
        chk("init_x", 32'(bus.x), 32'd0);
        chk("init_y", 32'(bus.y), 32'd0);
        chk("init_colour", 32'(bus.colour), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        set_rect(REQ_BALL, 10, 20, 2, 2, 7);
        bus.req = 4'b1000;
        run_txn(1'b0, 1'b0);

        set_rect(REQ_LPAD, 40, 40, 0, 5, 2);
        bus.req = 4'b0010;
        run_txn(1'b0, 1'b0);

        set_rect(REQ_RPAD, 158, 118, 4, 4, 6);
        bus.req = 4'b0100;
        run_txn(1'b0, 1'b0);

        set_rect(REQ_CLEAR, 30, 40, 5, 3, 5);
        bus.req = 4'b0001;
        run_txn(1'b1, 1'b0);

        tick();
        do_reset();
        for (int i = 0; i < 4; i++)
            set_rect(i, int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
                     1, 1, int'($urandom_range(0, 7)));
        bus.req = 4'b1111;
        for (int t = 0; t < 8; t++) run_txn(1'b0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 4; i++)
                set_rect(i, int'($urandom_range(0, 170)), int'($urandom_range(0, 130)),
                         int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
                         int'($urandom_range(0, 7)));
            bus.req = 4'($urandom_range(0, 15));
            if (bus.req == 4'b0) bus.req[$urandom_range(0, 3)] = 1'b1;
            run_txn(1'b0, 1'($urandom_range(0, 2) == 0));
        end

        set_rect(REQ_LPAD, 5, 5, 1, 1, 1);
        bus.req = 4'b0010;
        run_txn(1'b0, 1'b0);

        set_rect(REQ_CLEAR, 0, 0, 160, 120, 0);
        bus.req = 4'b0001;
        tick();
        chk("big_grant", 32'(bus.grant), 32'b0001);
        cnt = 0;
        for (int k = 0; k < 600 && cnt < 500; k++) begin
            tick();
            if (bus.plot) cnt++;
        end
        chk("big_count", 32'(cnt), 32'd500);
        chk("big_x", 32'(bus.x), 32'd19);
        chk("big_y", 32'(bus.y), 32'd3);
        for (int i = 0; i < 4; i++) set_rect(i, 3 + i, 7 + i, 1, 1, i);
        bus.req = 4'b1111;
        do_reset();
        run_txn(1'b0, 1'b0);
        run_txn(1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
